mux_2to1: RTL and testbench



---
 rtl/mips_pkg.sv | 9 +
 rtl/mux_2to1_comb.sv | 23 ++
 rtl/mux_2to1.sv | 50 +++++
 tb/tb_mux_2to1.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants.
// Default datapath width and mux select encodings.
package mips_pkg;

    localparam int   DATA_WIDTH = 32;
    localparam logic SEL_IN0    = 1'b0;
    localparam logic SEL_IN1    = 1'b1;

endpackage

// File: rtl/mux_2to1_comb.sv
// Combinational 2-to-1 select core.
// Ports: in0, in1 (WIDTH), sel (1) -> out (WIDTH).
module mux_2to1_comb
    import mips_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    // An if, not a ternary, so an unknown sel falls to in0
    // instead of merging both operands bitwise.
    always_comb begin
        out = in0;
        if (sel == SEL_IN1) begin
            out = in1;
        end
    end

endmodule

// File: rtl/mux_2to1.sv
// 2-to-1 datapath mux with optional registered copy.
// Ports: clk, rst_n, in0, in1, sel, en -> out, out_q, out_valid.
module mux_2to1
    import mips_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid
);

    mux_2to1_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .in0 (in0),
        .in1 (in1),
        .sel (sel),
        .out (out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            out_q     <= out;
            out_valid <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_sel_in0: assert property (
        @(posedge clk) (sel === SEL_IN0) |-> (out == in0)
    );
    a_sel_in1: assert property (
        @(posedge clk) (sel === SEL_IN1) |-> (out == in1)
    );
    a_rst_clr: assert property (
        @(posedge clk) !rst_n |-> (out_q == '0)
    );
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Testbench for mux_2to1 (32-bit and 8-bit instances).
// Random stimulus checked against a behavioural model.
module tb_mux_2to1;

    logic        clk;
    logic        rst_n;
    logic [31:0] in0, in1, out, out_q;
    logic        sel, en, out_valid;
    logic [7:0]  a8, b8, out8, out_q8;
    logic        sel8, en8, out_valid8;

    int total = 0;
    int bad   = 0;

    // model of the registered path
    logic [31:0] mq;
    logic        mv;

    mux_2to1 #(.WIDTH(32)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (in0),
        .in1       (in1),
        .sel       (sel),
        .en        (en),
        .out       (out),
        .out_q     (out_q),
        .out_valid (out_valid)
    );

    mux_2to1 #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (a8),
        .in1       (b8),
        .sel       (sel8),
        .en        (en8),
        .out       (out8),
        .out_q     (out_q8),
        .out_valid (out_valid8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pick(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic s);
        return (s === 1'b1) ? b : a;
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        in0 = 32'h0; in1 = 32'h0; sel = 1'b0; en = 1'b1;
        a8 = 8'h0; b8 = 8'h0; sel8 = 1'b0; en8 = 1'b0;
        #1 rst_n = 1'b0;
        mq = '0; mv = 1'b0;
        #1;
        total++;
        if (out_q !== 32'h0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_async got q=%h v=%b want 0/0", out_q, out_valid);
        end
        // en held high during reset must not load anything
        in0 = 32'hDEADBEEF;
        @(posedge clk); @(posedge clk); #1;
        total++;
        if (out_q !== 32'h0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold got q=%h v=%b want 0/0", out_q, out_valid);
        end
        total++;
        if (out !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL reset_out got %h want deadbeef", out);
        end
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_comb();
        logic [31:0] pa [4];
        logic [31:0] pb [4];
        pa[0] = 32'hAAAAAAAA; pb[0] = 32'h55555555;
        pa[1] = 32'h12345678; pb[1] = 32'h87654321;
        pa[2] = 32'h00000000; pb[2] = 32'hFFFFFFFF;
        pa[3] = 32'hFFFFFFFF; pb[3] = 32'h00000000;
        for (int i = 0; i < 4; i++) begin
            in0 = pa[i]; in1 = pb[i];
            for (int s = 0; s < 2; s++) begin
                sel = s[0];
                #1;
                total++;
                if (out !== (s == 1 ? pb[i] : pa[i])) begin
                    bad++;
                    $display("FAIL comb_%0d_%0d got %h want %h", i, s, out,
                             s == 1 ? pb[i] : pa[i]);
                end
            end
        end
    endtask

    task automatic test_load_hold();
        logic [31:0] keep;
        @(negedge clk);
        in0 = 32'h12345678; in1 = 32'h87654321; sel = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        mq = 32'h87654321; mv = 1'b1;
        total++;
        if (out_q !== mq || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL load got q=%h v=%b want %h/1", out_q, out_valid, mq);
        end
        @(negedge clk);
        en = 1'b0;
        keep = mq;
        in0 = $urandom; in1 = $urandom; sel = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_q !== keep || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold got q=%h v=%b want %h/1", out_q, out_valid, keep);
        end
        total++;
        if (out !== in0) begin
            bad++;
            $display("FAIL hold_out got %h want %h", out, in0);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        en = 1'b1;
        in0 = 32'h0BADF00D; in1 = 32'hCAFEBABE; sel = 1'b1;
        #2 rst_n = 1'b0;
        mq = '0; mv = 1'b0;
        #1;
        total++;
        if (out_q !== 32'h0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset got q=%h v=%b want 0/0", out_q, out_valid);
        end
        total++;
        if (out !== 32'hCAFEBABE) begin
            bad++;
            $display("FAIL midreset_out got %h want cafebabe", out);
        end
        @(posedge clk); #1;
        total++;
        if (out_q !== 32'h0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_en got q=%h v=%b want 0/0", out_q, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in0 = 32'hFFFFFFFF; sel = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        mq = 32'hFFFFFFFF; mv = 1'b1;
        total++;
        if (out_q !== mq || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL release got q=%h v=%b want ffffffff/1", out_q,
                     out_valid);
        end
    endtask

    task automatic test_width8();
        logic [7:0] exp8;
        a8 = 8'h0F; b8 = 8'hF0;
        sel8 = 1'b0; #1;
        total++;
        if (out8 !== 8'h0F) begin
            bad++;
            $display("FAIL w8_sel0 got %h want 0f", out8);
        end
        sel8 = 1'b1; #1;
        total++;
        if (out8 !== 8'hF0) begin
            bad++;
            $display("FAIL w8_sel1 got %h want f0", out8);
        end
        sel8 = 1'bx; #1;
        // a two-state simulator may turn X into a definite 0/1
        exp8 = (sel8 === 1'b1) ? b8 : a8;
        total++;
        if (out8 !== exp8) begin
            bad++;
            $display("FAIL w8_selx got %h want %h", out8, exp8);
        end
        sel8 = 1'b0;
        total++;
        if (out_q8 !== 8'h0 || out_valid8 !== 1'b0) begin
            bad++;
            $display("FAIL w8_noload got q=%h v=%b want 00/0", out_q8, out_valid8);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        logic        e;
        logic        r;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            in0 = $urandom; in1 = $urandom;
            sel = 1'($urandom_range(0, 1));
            e = 1'($urandom_range(0, 1));
            en = e;
            r = ($urandom_range(0, 19) == 0);
            #1;
            exp = pick(in0, in1, sel);
            total++;
            if (out !== exp) begin
                bad++;
                $display("FAIL rnd_out[%0d] got %h want %h", i, out, exp);
            end
            if (r) begin
                rst_n = 1'b0;
                mq = '0; mv = 1'b0;
                #1;
                total++;
                if (out_q !== 32'h0 || out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_rst[%0d] got q=%h v=%b want 0/0", i,
                             out_q, out_valid);
                end
            end
            @(posedge clk);
            if (e && rst_n) begin
                mq = exp;
                mv = 1'b1;
            end
            #1;
            total++;
            if (out_q !== mq || out_valid !== mv) begin
                bad++;
                $display("FAIL rnd_q[%0d] got q=%h v=%b want %h/%b", i, out_q,
                         out_valid, mq, mv);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_comb();
        test_load_hold();
        test_async_reset();
        test_width8();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
